// File: rtl/regfile_write_arbiter.sv
// Two-source arbiter for the single register-file write port.
// Source A has priority; a bounded starvation counter forces a grant to source B.
module regfile_write_arbiter #(
   parameter int WIDTH        = 32,
   parameter int REGSIZE      = 5,
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               aValid,
   output logic               aReady,
   input  logic [REGSIZE-1:0] aAddress,
   input  logic [WIDTH-1:0]   aValue,
   input  logic               bValid,
   output logic               bReady,
   input  logic [REGSIZE-1:0] bAddress,
   input  logic [WIDTH-1:0]   bValue,
   output logic               writeEnable,
   output logic [REGSIZE-1:0] writeAddress,
   output logic [WIDTH-1:0]   writeValue,
   output logic [CNT_W-1:0]   starveEvents
);

   localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

   typedef enum logic {
      NORMAL = 1'b0,
      FORCE  = 1'b1
   } arbMode_e;

   logic [WAIT_W-1:0]  waitCount;
   logic [WAIT_W-1:0]  waitNext;
   arbMode_e           mode;
   logic               aGrant;
   logic               bGrant;
   logic               vld_p0;
   logic [REGSIZE-1:0] selAddress_p0;
   logic [WIDTH-1:0]   selValue_p0;

   function automatic logic [CNT_W-1:0] satIncEvents(input logic [CNT_W-1:0] cnt);
      return (&cnt) ? cnt : cnt + CNT_W'(1);
   endfunction

   // Stage p0: combinational grant and source selection
   always_comb begin
      mode          = (waitCount == WAIT_MAX) ? FORCE : NORMAL;
      bGrant        = bValid && (!aValid || mode == FORCE);
      aGrant        = aValid && !bGrant;
      vld_p0        = aGrant || bGrant;
      selAddress_p0 = bGrant ? bAddress : aAddress;
      selValue_p0   = bGrant ? bValue : aValue;
   end

   assign aReady = aGrant;
   assign bReady = bGrant;

   // waitCount measures how long the current B request has been denied
   always_comb begin
      waitNext = waitCount;
      if (bGrant || !bValid) begin
         waitNext = '0;
      end else if (waitCount != WAIT_MAX) begin
         waitNext = waitCount + WAIT_W'(1);
      end
   end

   // Stage p1: registered write port and event counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         waitCount    <= '0;
         writeEnable  <= 1'b0;
         writeAddress <= '0;
         writeValue   <= '0;
         starveEvents <= '0;
      end else begin
         waitCount   <= waitNext;
         writeEnable <= 1'b0;
         if (vld_p0) begin
            writeAddress <= selAddress_p0;
            writeValue   <= selValue_p0;
            writeEnable  <= (selAddress_p0 != '0);
         end
         if (bGrant && aValid) begin
            starveEvents <= satIncEvents(starveEvents);
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomised and directed checks of regfile_write_arbiter against a
// request-level reference model of the arbitration rules and register file.
module tb_regfile_write_arbiter;

   localparam int WIDTH   = 32;
   localparam int REGSIZE = 5;
   localparam int LIMIT   = 4;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               aValid = 1'b0;
   logic [REGSIZE-1:0] aAddress = '0;
   logic [WIDTH-1:0]   aValue = '0;
   logic               bValid = 1'b0;
   logic [REGSIZE-1:0] bAddress = '0;
   logic [WIDTH-1:0]   bValue = '0;

   logic               aReady, bReady, writeEnable;
   logic [REGSIZE-1:0] writeAddress;
   logic [WIDTH-1:0]   writeValue;
   logic [15:0]        starveEvents;

   logic               aReadyS, bReadyS, writeEnableS;
   logic [REGSIZE-1:0] writeAddressS;
   logic [WIDTH-1:0]   writeValueS;
   logic [1:0]         starveEventsS;

   regfile_write_arbiter #(.WIDTH(WIDTH), .REGSIZE(REGSIZE), .STARVE_LIMIT(LIMIT), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .aValid(aValid), .aReady(aReady), .aAddress(aAddress), .aValue(aValue),
      .bValid(bValid), .bReady(bReady), .bAddress(bAddress), .bValue(bValue),
      .writeEnable(writeEnable), .writeAddress(writeAddress), .writeValue(writeValue),
      .starveEvents(starveEvents)
   );

   regfile_write_arbiter #(.WIDTH(WIDTH), .REGSIZE(REGSIZE), .STARVE_LIMIT(LIMIT), .CNT_W(2)) dutSat (
      .clk(clk), .rst_n(rst_n),
      .aValid(aValid), .aReady(aReadyS), .aAddress(aAddress), .aValue(aValue),
      .bValid(bValid), .bReady(bReadyS), .bAddress(bAddress), .bValue(bValue),
      .writeEnable(writeEnableS), .writeAddress(writeAddressS), .writeValue(writeValueS),
      .starveEvents(starveEventsS)
   );

   always #5 clk = ~clk;

   // Register file driven by the DUT's write port
   logic [WIDTH-1:0] dRegs [32] = '{default: '0};
   always @(posedge clk) begin
      if (writeEnable) dRegs[writeAddress] <= writeValue;
   end

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   int               mWaited = 0;   // cycles the current B request has been refused
   int               mStarve = 0;
   int               mSat = 0;
   bit               mWe = 1'b0;
   logic [REGSIZE-1:0] mWa = '0;
   logic [WIDTH-1:0] mWv = '0;
   logic [WIDTH-1:0] mRegs [32] = '{default: '0};
   bit               obsA, obsB;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mWaited = 0; mStarve = 0; mSat = 0;
      mWe = 1'b0; mWa = '0; mWv = '0;
   endtask

   // One clock cycle: drive requests, check readies, then check the registered port.
   task automatic step(input bit av, input logic [REGSIZE-1:0] aa, input logic [WIDTH-1:0] ad,
                       input bit bv, input logic [REGSIZE-1:0] ba, input logic [WIDTH-1:0] bd);
      bit aG, bG;
      @(negedge clk);
      aValid = av; aAddress = aa; aValue = ad;
      bValid = bv; bAddress = ba; bValue = bd;
      #1;
      bG = bv && (!av || mWaited >= LIMIT);
      aG = av && !bG;
      obsA = aReady;
      obsB = bReady;
      chk("aReady", {63'd0, aReady}, {63'd0, aG});
      chk("bReady", {63'd0, bReady}, {63'd0, bG});
      chk("bReadySat", {63'd0, bReadyS}, {63'd0, bG});
      @(posedge clk);
      if (mWe) mRegs[mWa] = mWv;
      mWe = 1'b0;
      if (aG || bG) begin
         mWa = bG ? ba : aa;
         mWv = bG ? bd : ad;
         mWe = (mWa != 0);
      end
      if (bG && av) begin
         if (mStarve < 65535) mStarve++;
         if (mSat < 3) mSat++;
      end
      mWaited = (bG || !bv) ? 0 : mWaited + 1;
      #1;
      chk("writeEnable", {63'd0, writeEnable}, {63'd0, mWe});
      if (mWe) begin
         chk("writeAddress", {59'd0, writeAddress}, {59'd0, mWa});
         chk("writeValue", {32'd0, writeValue}, {32'd0, mWv});
      end
      chk("starveEvents", {48'd0, starveEvents}, 64'(mStarve));
      chk("starveEventsSat", {62'd0, starveEventsS}, 64'(mSat));
   endtask

   initial begin
      bit aP, bP;
      logic [REGSIZE-1:0] aA, bA;
      logic [WIDTH-1:0] aD, bD;

      // Reset state
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      chk("rstWriteEnable", {63'd0, writeEnable}, 64'd0);
      chk("rstWriteAddress", {59'd0, writeAddress}, 64'd0);
      chk("rstWriteValue", {32'd0, writeValue}, 64'd0);
      chk("rstStarve", {48'd0, starveEvents}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // A only
      step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
      chk("aOnlyReady", {63'd0, obsA}, 64'd1);
      chk("aOnlyWe", {63'd0, writeEnable}, 64'd1);
      chk("aOnlyAddr", {59'd0, writeAddress}, 64'd5);
      chk("aOnlyValue", {32'd0, writeValue}, 64'hDEADBEEF);

      // B only
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h0BADF00D);
      chk("bOnlyReady", {63'd0, obsB}, 64'd1);
      chk("bOnlyStarve", {48'd0, starveEvents}, 64'd0);

      // Zero register is accepted but never written
      step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0);
      chk("zeroReady", {63'd0, obsA}, 64'd1);
      chk("zeroWe", {63'd0, writeEnable}, 64'd0);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

      // Starvation, repeated five times to saturate the 2-bit counter
      for (int k = 0; k < 5; k++) begin
         for (int c = 0; c <= LIMIT; c++) begin
            step(1'b1, 5'd5, 32'h100 + c, 1'b1, 5'd7, 32'hB0 + k);
            chk("starveBReady", {63'd0, obsB}, (c == LIMIT) ? 64'd1 : 64'd0);
            chk("starveAReady", {63'd0, obsA}, (c == LIMIT) ? 64'd0 : 64'd1);
         end
         if (k == 0) chk("starveCount1", {48'd0, starveEvents}, 64'd1);
         // waitCount is back to 0: a fresh B request is refused again
         step(1'b1, 5'd6, 32'h200, 1'b1, 5'd8, 32'h300);
         chk("starveRestart", {63'd0, obsB}, 64'd0);
         step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      end
      chk("starveCount5", {48'd0, starveEvents}, 64'd5);
      chk("starveSat3", {62'd0, starveEventsS}, 64'd3);

      // Reset in the middle of a write
      step(1'b1, 5'd9, 32'h12345678, 1'b0, 5'd0, 32'd0);
      chk("preRstWe", {63'd0, writeEnable}, 64'd1);
      #2;
      rst_n = 1'b0;
      modelReset();
      #1;
      chk("midRstWe", {63'd0, writeEnable}, 64'd0);
      chk("midRstAddr", {59'd0, writeAddress}, 64'd0);
      chk("midRstStarve", {48'd0, starveEvents}, 64'd0);
      chk("midRstAReady", {63'd0, aReady}, 64'd1);
      @(posedge clk);
      #1;
      chk("inRstWe", {63'd0, writeEnable}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      aValid = 1'b0;
      #1;
      chk("rstDropped", {32'd0, dRegs[9]}, {32'd0, mRegs[9]});

      // Randomised traffic honouring the hold-until-transfer protocol
      aP = 1'b0; bP = 1'b0; aA = '0; bA = '0; aD = '0; bD = '0;
      for (int n = 0; n < 400; n++) begin
         if (!aP && $urandom_range(0, 9) < 7) begin
            aP = 1'b1; aA = 5'($urandom_range(0, 7)); aD = $urandom;
         end
         if (!bP && $urandom_range(0, 9) < 4) begin
            bP = 1'b1; bA = 5'($urandom_range(0, 7)); bD = $urandom;
         end
         step(aP, aA, aD, bP, bA, bD);
         if (obsA) aP = 1'b0;
         if (obsB) bP = 1'b0;
      end

      // Flush the last write, then compare register file contents
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      for (int r = 0; r < 32; r++) begin
         chk("regfile", {32'd0, dRegs[r]}, {32'd0, mRegs[r]});
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
